// File: rtl/regwb_pkg.sv
// Shared constants and types for the register-bank writeback arbiter.
// The requester IDs are the encoding of the round-robin "last granted" pointer.
package regwb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NREGS      = 2 ** ADDR_WIDTH;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO with no push/pop bypass. Every slot and its
// occupancy bit are visible so the owner can scan queued destinations.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [WIDTH-1:0]              head,
    output logic [DEPTH-1:0][WIDTH-1:0]   entries,
    output logic [DEPTH-1:0]              valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] offset;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; occupancy is tracked by
    // count, so stale slot contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= din;
    end

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        offset = '0;
        valid  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PW'(i) - rd_ptr;
            valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank's single write port between the ALU (A) and load (B)
// writeback paths with round-robin arbitration and a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = regwb_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regwb_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ADDR_WIDTH-1:0]      a_reg,
    input  logic [DATA_WIDTH-1:0]      a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [ADDR_WIDTH-1:0]      b_reg,
    input  logic [DATA_WIDTH-1:0]      b_data,
    output logic                       wb_en,
    output logic [ADDR_WIDTH-1:0]      wb_reg,
    output logic [DATA_WIDTH-1:0]      wb_data,
    input  logic [ADDR_WIDTH-1:0]      qry_rs,
    input  logic [ADDR_WIDTH-1:0]      qry_rt,
    output logic                       hazard,
    output logic [2**ADDR_WIDTH-1:0]   pending,
    output logic                       idle
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    import regwb_pkg::*;

    logic                      a_full, a_empty, b_full, b_empty;
    logic [CW-1:0]             a_count, b_count;
    logic [EW-1:0]             a_head, b_head;
    logic [DEPTH-1:0][EW-1:0]  a_entries, b_entries;
    logic [DEPTH-1:0]          a_slot_valid, b_slot_valid;
    logic                      grant_a, grant_b;
    logic                      last_grant;

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .reset   (reset),
        .push    (a_valid && !reset),
        .pop     (grant_a),
        .din     ({a_reg, a_data}),
        .full    (a_full),
        .empty   (a_empty),
        .count   (a_count),
        .head    (a_head),
        .entries (a_entries),
        .valid   (a_slot_valid)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .reset   (reset),
        .push    (b_valid && !reset),
        .pop     (grant_b),
        .din     ({b_reg, b_data}),
        .full    (b_full),
        .empty   (b_empty),
        .count   (b_count),
        .head    (b_head),
        .entries (b_entries),
        .valid   (b_slot_valid)
    );

    assign a_ready = !a_full;
    assign b_ready = !b_full;

    // On contention the requester not granted last wins.
    assign grant_a = !a_empty && (b_empty || last_grant == REQ_B);
    assign grant_b = !b_empty && !grant_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_en      <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            last_grant <= REQ_B;
        end else if (grant_a) begin
            wb_en      <= (a_head[EW-1 -: ADDR_WIDTH] != '0);
            wb_reg     <= a_head[EW-1 -: ADDR_WIDTH];
            wb_data    <= a_head[DATA_WIDTH-1:0];
            last_grant <= REQ_A;
        end else if (grant_b) begin
            wb_en      <= (b_head[EW-1 -: ADDR_WIDTH] != '0);
            wb_reg     <= b_head[EW-1 -: ADDR_WIDTH];
            wb_data    <= b_head[DATA_WIDTH-1:0];
            last_grant <= REQ_B;
        end else begin
            wb_en      <= 1'b0;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_slot_valid[i]) pending[a_entries[i][EW-1 -: ADDR_WIDTH]] = 1'b1;
            if (b_slot_valid[i]) pending[b_entries[i][EW-1 -: ADDR_WIDTH]] = 1'b1;
        end
        if (wb_en) pending[wb_reg] = 1'b1;
        pending[0] = 1'b0;
    end

    assign hazard = (qry_rs != '0 && pending[qry_rs]) || (qry_rt != '0 && pending[qry_rt]);
    assign idle   = (a_count == '0) && (b_count == '0) && !wb_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: reset state, latency,
// round-robin order, backpressure, $0 writes, hazard query and mid-run reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [4:0]  qry_rs, qry_rt;
    logic        hazard;
    logic [31:0] pending;
    logic        idle;

    int passed = 0;
    int total  = 0;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_reg   (a_reg),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_reg   (b_reg),
        .b_data  (b_data),
        .wb_en   (wb_en),
        .wb_reg  (wb_reg),
        .wb_data (wb_data),
        .qry_rs  (qry_rs),
        .qry_rt  (qry_rt),
        .hazard  (hazard),
        .pending (pending),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        reset   = 1'b0;
    endtask

    int          ai, bi, oi;
    logic        ar, br, seen_a_full;
    logic [31:0] exp_reg, exp_data;

    initial begin
        a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
        qry_rs = '0; qry_rt = '0;
        do_reset();
        step();

        // Reset state
        check("rst_wb_en",   32'(wb_en),   32'd0);
        check("rst_wb_reg",  32'(wb_reg),  32'd0);
        check("rst_wb_data", wb_data,      32'd0);
        check("rst_pending", pending,      32'd0);
        check("rst_hazard",  32'(hazard),  32'd0);
        check("rst_idle",    32'(idle),    32'd1);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);

        // Single write: push at edge 1, output in cycle 2 only
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        step();
        a_valid = 1'b0;
        check("single_c1_wb_en",   32'(wb_en), 32'd0);
        check("single_c1_pending", pending,    32'h0000_0020);
        check("single_c1_idle",    32'(idle),  32'd0);
        step();
        check("single_c2_wb_en",   32'(wb_en),  32'd1);
        check("single_c2_wb_reg",  32'(wb_reg), 32'd5);
        check("single_c2_wb_data", wb_data,     32'hDEADBEEF);
        check("single_c2_pending", pending,     32'h0000_0020);
        step();
        check("single_c3_wb_en",   32'(wb_en), 32'd0);
        check("single_c3_pending", pending,    32'd0);
        check("single_c3_idle",    32'(idle),  32'd1);
        check("single_c3_hold",    wb_data,    32'hDEADBEEF);

        // Contention after reset: A wins first
        do_reset();
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        check("cont_c1_wb_en", 32'(wb_en), 32'd0);
        step();
        check("cont_first_reg",  32'(wb_reg), 32'd3);
        check("cont_first_data", wb_data,     32'h11);
        check("cont_first_en",   32'(wb_en),  32'd1);
        step();
        check("cont_second_reg",  32'(wb_reg), 32'd4);
        check("cont_second_data", wb_data,     32'h22);
        check("cont_second_en",   32'(wb_en),  32'd1);
        step();
        check("cont_done_en", 32'(wb_en), 32'd0);

        // Saturation + backpressure: both streams push whenever ready
        do_reset();
        ai = 0; bi = 0; oi = 0; seen_a_full = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            a_reg  = 5'(8 + ai);  a_data = 32'hA000_0000 + 32'(ai);
            b_reg  = 5'(16 + bi); b_data = 32'hB000_0000 + 32'(bi);
            ar = a_ready; br = b_ready;
            if (!a_ready) seen_a_full = 1'b1;
            step();
            if (ar) ai++;
            if (br) bi++;
            if (wb_en) begin
                if (oi % 2 == 0) begin
                    exp_reg  = 32'(8 + oi / 2);
                    exp_data = 32'hA000_0000 + 32'(oi / 2);
                end else begin
                    exp_reg  = 32'(16 + oi / 2);
                    exp_data = 32'hB000_0000 + 32'(oi / 2);
                end
                check("rr_reg",  32'(wb_reg), exp_reg);
                check("rr_data", wb_data,     exp_data);
                oi++;
            end
        end
        check("rr_output_count", 32'(oi), 32'd9);
        check("a_backpressure",  32'(seen_a_full), 32'd1);

        // Write to $0 is consumed silently
        do_reset();
        qry_rs = 5'd0; qry_rt = 5'd0;
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF;
        step();
        b_valid = 1'b0;
        check("r0_c1_pending", pending,    32'd0);
        check("r0_c1_hazard",  32'(hazard), 32'd0);
        check("r0_c1_idle",    32'(idle),  32'd0);
        step();
        check("r0_c2_wb_en",   32'(wb_en), 32'd0);
        check("r0_c2_pending", pending,    32'd0);
        check("r0_c2_idle",    32'(idle),  32'd1);

        // Hazard on a queued r7, then unrelated query addresses
        qry_rs = 5'd8; qry_rt = 5'd7;
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
        step();
        a_valid = 1'b0;
        check("haz_c1", 32'(hazard), 32'd1);
        step();
        check("haz_c2_wb_reg", 32'(wb_reg), 32'd7);
        check("haz_c2",        32'(hazard), 32'd1);
        step();
        check("haz_c3", 32'(hazard), 32'd0);
        qry_rs = 5'd8; qry_rt = 5'd9;
        a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h78;
        step();
        a_valid = 1'b0;
        check("nohaz_c1", 32'(hazard), 32'd0);
        step();
        check("nohaz_c2", 32'(hazard), 32'd0);
        step();
        check("nohaz_c3", 32'(hazard), 32'd0);

        // Reset mid-operation, with pushes still presented during reset
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        a_reg = 5'd12; a_data = 32'hC0; b_reg = 5'd13; b_data = 32'hD0;
        step();
        a_reg = 5'd14; a_data = 32'hC1; b_reg = 5'd15; b_data = 32'hD1;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        check("mid_rst_wb_en",   32'(wb_en),   32'd0);
        check("mid_rst_pending", pending,      32'd0);
        check("mid_rst_idle",    32'(idle),    32'd1);
        check("mid_rst_a_ready", 32'(a_ready), 32'd1);
        check("mid_rst_b_ready", 32'(b_ready), 32'd1);
        step();
        check("mid_rst_after1_wb_en", 32'(wb_en), 32'd0);
        step();
        check("mid_rst_after2_wb_en", 32'(wb_en), 32'd0);
        check("mid_rst_after2_idle",  32'(idle),  32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
